beehive_frame_arbiter: RTL

Frame-granular round-robin arbiter that lets NUM_SRCS Beehive-format receive streams share one downstream consumer, such as a single packet-processing pipeline fed from several receive converters. It grants one source for one whole frame, from the startframe line through the endframe line, and tags each output line with the granted source index. It never interleaves lines from different frames. Grant is held while the consumer stalls, so output contents stay stable until accepted.

---
 rtl/beehive_frame_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/beehive_frame_arbiter.sv
// Frame-granular round-robin arbiter: merges NUM_SRCS Beehive receive streams into one
// consumer, holding each grant from startframe through endframe and tagging lines with the source.
`ifndef MAC_INTERFACE_W
`define MAC_INTERFACE_W 512
`endif
`ifndef MTU_SIZE_W
`define MTU_SIZE_W 16
`endif
`ifndef MAC_PADBYTES_W
`define MAC_PADBYTES_W 6
`endif

module beehive_frame_arbiter #(
    parameter int NUM_SRCS = 2,
    parameter int SRC_ID_W = $clog2(NUM_SRCS)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_SRCS-1:0]                   src_arb_val,
    input  logic [NUM_SRCS*`MAC_INTERFACE_W-1:0]  src_arb_data,
    input  logic [NUM_SRCS-1:0]                   src_arb_startframe,
    input  logic [NUM_SRCS*`MTU_SIZE_W-1:0]       src_arb_frame_size,
    input  logic [NUM_SRCS-1:0]                   src_arb_endframe,
    input  logic [NUM_SRCS*`MAC_PADBYTES_W-1:0]   src_arb_padbytes,
    output logic [NUM_SRCS-1:0]                   arb_src_rdy,
    output logic                                  arb_dst_val,
    output logic [`MAC_INTERFACE_W-1:0]           arb_dst_data,
    output logic                                  arb_dst_startframe,
    output logic [`MTU_SIZE_W-1:0]                arb_dst_frame_size,
    output logic                                  arb_dst_endframe,
    output logic [`MAC_PADBYTES_W-1:0]            arb_dst_padbytes,
    output logic [SRC_ID_W-1:0]                   arb_dst_src_id,
    input  logic                                  dst_arb_rdy
);

    localparam int DW = `MAC_INTERFACE_W;
    localparam int FW = `MTU_SIZE_W;
    localparam int PW = `MAC_PADBYTES_W;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t              state_reg, state_next;
    logic [SRC_ID_W-1:0] lock_id_reg, lock_id_next;
    logic [SRC_ID_W-1:0] rr_ptr_reg, rr_ptr_next;

    logic [DW-1:0]       data_arr [NUM_SRCS];
    logic [FW-1:0]       fsize_arr [NUM_SRCS];
    logic [PW-1:0]       pad_arr [NUM_SRCS];

    logic                found;
    logic [SRC_ID_W-1:0] winner;
    logic [SRC_ID_W-1:0] sel;
    logic                locked;
    logic                grant_val;
    logic                end_hs;

    // Wraps explicitly so non-power-of-two source counts never produce an out-of-range index.
    function automatic logic [SRC_ID_W-1:0] next_idx(input logic [SRC_ID_W-1:0] i);
        return (int'(i) == NUM_SRCS - 1) ? '0 : i + SRC_ID_W'(1);
    endfunction

    generate
        for (genvar gi = 0; gi < NUM_SRCS; gi++) begin : g_unpack
            assign data_arr[gi]    = src_arb_data[gi*DW +: DW];
            assign fsize_arr[gi]   = src_arb_frame_size[gi*FW +: FW];
            assign pad_arr[gi]     = src_arb_padbytes[gi*PW +: PW];
            assign arb_src_rdy[gi] = !rst && (locked || found) &&
                                     (sel == SRC_ID_W'(gi)) && dst_arb_rdy;
        end
    endgenerate

    // Circular search from rr_ptr; iterating backwards leaves the nearest requester as winner.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = NUM_SRCS - 1; k >= 0; k--) begin
            int idx;
            idx = int'(rr_ptr_reg) + k;
            if (idx >= NUM_SRCS) idx = idx - NUM_SRCS;
            if (src_arb_val[idx]) begin
                found  = 1'b1;
                winner = SRC_ID_W'(idx);
            end
        end
    end

    assign locked    = (state_reg == LOCKED);
    assign sel       = locked ? lock_id_reg : winner;
    assign grant_val = locked ? src_arb_val[sel] : found;
    assign end_hs    = grant_val && dst_arb_rdy && src_arb_endframe[sel];

    assign arb_dst_val        = grant_val && !rst;
    assign arb_dst_data       = data_arr[sel];
    assign arb_dst_startframe = src_arb_startframe[sel];
    assign arb_dst_frame_size = fsize_arr[sel];
    assign arb_dst_endframe   = src_arb_endframe[sel];
    assign arb_dst_padbytes   = pad_arr[sel];
    assign arb_dst_src_id     = (locked || found) ? sel : '0;

    always_comb begin
        state_next   = state_reg;
        lock_id_next = lock_id_reg;
        rr_ptr_next  = rr_ptr_reg;
        case (state_reg)
            IDLE: begin
                if (found) begin
                    if (end_hs) begin
                        rr_ptr_next = next_idx(winner);
                    end else begin
                        // Lock even on a stall so the presented line stays put.
                        state_next   = LOCKED;
                        lock_id_next = winner;
                    end
                end
            end
            LOCKED: begin
                if (end_hs) begin
                    state_next  = IDLE;
                    rr_ptr_next = next_idx(lock_id_reg);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            lock_id_reg <= '0;
            rr_ptr_reg  <= '0;
        end else begin
            state_reg   <= state_next;
            lock_id_reg <= lock_id_next;
            rr_ptr_reg  <= rr_ptr_next;
        end
    end

endmodule
